deserializer_frame: RTL
=======================

// Module: deserializer_frame
// PURPOSE
//  Input stage ahead of fft_fp: gathers SIO_SIZE-bit serial beats into one
//  PIO_SIZE-bit frame (N words of WORD_SIZE) and issues a one-cycle start to fft_fp.
//  Mirror of the output serializer.
//  Double-buffered, so the next frame can be collected while the FFT runs.
//  Back-pressures the source only when both buffers are occupied.
// PARAMETERS
//  N          8   FFT points (words per frame)
//  WORD_SIZE  32  bits per complex word
//  SIO_SIZE   16  serial beat width; PIO_SIZE (N*WORD_SIZE) % SIO_SIZE must be 0
//  (derived) PIO_SIZE = N*WORD_SIZE; BEATS = PIO_SIZE/SIO_SIZE (default 16)
// PORTS
//  clk           in   1         sole clock, rising edge
//  reset         in   1         synchronous, active-high
//  serial_in     in   SIO_SIZE  beat data
//  in_valid      in   1         beat present on serial_in
//  in_sof        in   1         qualifies first beat of a frame (with in_valid)
//  in_ready      out  1         stage can accept a beat this cycle
//  fft_done      in   1         done pulse from fft_fp; frees the FFT
//  parallel_out  out  PIO_SIZE  frame to fft_fp.inputs; stable between starts
//  start         out  1         one-cycle pulse to fft_fp.start
//  frame_err     out  1         one-cycle pulse: partial frame discarded
// BEHAVIOUR
//  Interface: one clock clk; reset is synchronous and active-high.
//  - Reset values: in_ready=1, start=0, frame_err=0, parallel_out=0.
//    Internal state cleared: beat_cnt=0, coll_full=0, fft_busy=0.
//    Reset mid-frame drops the partial frame silently (no frame_err).
//  - Beat accepted when in_valid & in_ready.
//    Beat k is written to coll_buf[k*SIO_SIZE +: SIO_SIZE].
//    Beat 0 fills the LSBs of word 0; the same ordering applies to the output serializer.
//  - beat_cnt: 0..BEATS-1, wraps to 0 on the last beat, which sets coll_full.
//  - in_sof on an accepted beat:
//    - beat_cnt==0: normal.
//    - beat_cnt!=0: discard partial, store beat at index 0, set beat_cnt=1,
//      pulse frame_err next cycle.
//  - in_sof low on beat 0 is accepted (sof optional).
//  - Launch: when coll_full & !fft_busy, at the next edge:
//    - parallel_out<=coll_buf, start=1 for one cycle
//    - coll_full<=0, fft_busy<=1
//  - Latency: last beat accepted at edge t with FFT idle ->
//    start and new parallel_out visible after edge t+1.
//  - fft_busy clears on fft_done. fft_done and a launch in the same cycle:
//    the launch waits for fft_busy=0 seen at an edge, so start comes one cycle after fft_done.
//  - in_ready = !coll_full. While the collection buffer waits for the FFT, the source is stalled.
//    The cycle the launch happens, in_ready is still 0; it rises the cycle after.
//  - in_valid while in_ready=0: no effect; the source holds the beat.
//  - parallel_out never changes except on a start cycle.
//  - Launch condition is an FSM: IDLE(!coll_full), PEND(coll_full&fft_busy),
//    LAUNCH(1 cycle, start=1), then IDLE.
// STRUCTURE
//  - Shared package/header fft_params: N, WORD_SIZE, SIO_SIZE, PIO_SIZE, BEATS,
//    plus clog2 width for beat_cnt. Shared with top and the serializer.
//  - One natural sub-module: deser_beat_counter (beat_cnt, wrap, sof resync, frame_err).
//  - Buffers and launch FSM stay in this module.
//  - Top integration: parallel_out->fft_fp.inputs, start->fft_fp.start,
//    fft_fp.done->fft_done.
// TESTING
//  1. reset; 16 beats 16'h0000..16'h000F with sof on beat 0 ->
//     start 1 cycle after beat 15; parallel_out = {16'h000F,...,16'h0001,16'h0000}.
//  2. Two back-to-back frames, fft_done withheld 40 cycles ->
//     in_ready=0 after frame 2 beat 15; second start 1 cycle after fft_done;
//     second parallel_out correct.
//  3. sof at beat 5 of frame (data 16'hA5A5) ->
//     frame_err pulse once; frame completes 15 beats later; word 0 LSBs = 16'hA5A5.
//  4. Random in_valid gaps (50% duty) ->
//     frame content identical to case 1; exactly one start per 16 accepted beats.
//  5. reset asserted at beat 9 ->
//     outputs return to reset values next cycle; no start, no frame_err;
//     a full frame after reset launches normally.
//  6. fft_done asserted in the same cycle coll_full sets ->
//     start on the following cycle; never two starts without an intervening fft_done.

Source files
------------

// File: rtl/deserializer_frame_pkg.sv
// Shared frame geometry for the FFT serial front end and back end.
// Beat k of a frame occupies bits [k*SIO_SIZE +: SIO_SIZE] of the parallel word.
package deserializer_frame_pkg;

  localparam int unsigned N          = 8;
  localparam int unsigned WORD_SIZE  = 32;
  localparam int unsigned SIO_SIZE   = 16;
  localparam int unsigned PIO_SIZE   = N * WORD_SIZE;
  localparam int unsigned BEATS      = PIO_SIZE / SIO_SIZE;
  localparam int unsigned BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StLaunch
  } launch_state_e;

endpackage

// File: rtl/deserializer_frame_beat_counter.sv
// Tracks the beat position within the frame being collected, resynchronising on a
// mid-frame start-of-frame and flagging the discarded partial frame.
module deserializer_frame_beat_counter
  import deserializer_frame_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  beat_i,
  input  logic                  sof_i,
  output logic [BEAT_CNT_W-1:0] wr_idx_o,
  output logic                  last_o,
  output logic                  frame_err_o
);

  localparam logic [BEAT_CNT_W-1:0] LastIdx = BEAT_CNT_W'(BEATS - 1);

  logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  resync;

  assign resync = beat_i & sof_i & (cnt_q != '0);

  always_comb begin
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    last_o   = 1'b0;
    wr_idx_o = resync ? '0 : cnt_q;
    if (beat_i) begin
      if (resync) begin
        // The sof beat becomes beat 0 of a fresh frame.
        cnt_d = BEAT_CNT_W'(1);
        err_d = 1'b1;
      end else if (cnt_q == LastIdx) begin
        cnt_d  = '0;
        last_o = 1'b1;
      end else begin
        cnt_d = cnt_q + BEAT_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign frame_err_o = err_q;

endmodule

// File: rtl/deserializer_frame.sv
// Serial-to-parallel input stage for fft_fp: collects BEATS beats into a frame and
// hands it over with a one-cycle start, collecting the next frame while the FFT runs.
module deserializer_frame
  import deserializer_frame_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [SIO_SIZE-1:0] serial_in,
  input  logic                in_valid,
  input  logic                in_sof,
  output logic                in_ready,
  input  logic                fft_done,
  output logic [PIO_SIZE-1:0] parallel_out,
  output logic                start,
  output logic                frame_err
);

  logic [PIO_SIZE-1:0]   coll_buf_q, coll_buf_d;
  logic [PIO_SIZE-1:0]   par_q, par_d;
  logic                  coll_full_q, coll_full_d;
  logic                  fft_busy_q, fft_busy_d;
  launch_state_e         state_q, state_d;
  logic                  beat_acc;
  logic                  launch_go;
  logic [BEAT_CNT_W-1:0] wr_idx;
  logic                  last_beat;

  assign beat_acc  = in_valid & in_ready;
  assign launch_go = coll_full_q & ~fft_busy_q;

  deserializer_frame_beat_counter u_beat_counter (
    .clk_i       (clk),
    .reset_i     (reset),
    .beat_i      (beat_acc),
    .sof_i       (in_sof),
    .wr_idx_o    (wr_idx),
    .last_o      (last_beat),
    .frame_err_o (frame_err)
  );

  always_comb begin
    coll_buf_d = coll_buf_q;
    if (beat_acc) begin
      coll_buf_d[wr_idx*SIO_SIZE +: SIO_SIZE] = serial_in;
    end
  end

  // Launch FSM: a full buffer waits in StPend until the FFT is idle, then StLaunch
  // emits start for exactly one cycle while the frame moves to the output register.
  always_comb begin
    state_d     = StIdle;
    par_d       = par_q;
    coll_full_d = coll_full_q;
    fft_busy_d  = fft_busy_q;
    if (fft_done) begin
      fft_busy_d = 1'b0;
    end
    if (launch_go) begin
      state_d     = StLaunch;
      par_d       = coll_buf_q;
      coll_full_d = 1'b0;
      fft_busy_d  = 1'b1;
    end else if (coll_full_q) begin
      state_d = StPend;
    end
    if (last_beat) begin
      coll_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      coll_buf_q  <= '0;
      par_q       <= '0;
      coll_full_q <= 1'b0;
      fft_busy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      coll_buf_q  <= coll_buf_d;
      par_q       <= par_d;
      coll_full_q <= coll_full_d;
      fft_busy_q  <= fft_busy_d;
    end
  end

  assign in_ready     = ~coll_full_q;
  assign start        = (state_q == StLaunch);
  assign parallel_out = par_q;

endmodule
